// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: state encodings and default
// payload widths for each stage boundary.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    localparam int IFU_IDU_W = 64;
    localparam int IDU_EXU_W = 96;
    localparam int EXU_WBU_W = 48;
    localparam int DEF_CNT_W = 16;

    // The state encoding doubles as the entry count.
    function automatic logic [1:0] occ_of(state_t s);
        case (s)
            ST_BUSY: occ_of = 2'd1;
            ST_FULL: occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones,
// cleared only by the asynchronous reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with optional 1-entry skid buffer, flush,
// bubble zeroing, occupancy and a saturating stall counter. Latency 1 cycle.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int W               = 32,
    parameter int SKID            = 1,
    parameter int CLEAR_ON_BUBBLE = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic [W-1:0] w_main_nxt;
    logic [W-1:0] w_skid_nxt;
    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_out_valid;

    assign w_out_valid = (r_state != ST_EMPTY);

    // With the skid buffer, ready depends only on state so no ready path
    // crosses the stage combinationally.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = ~reset & (r_state != ST_FULL);
        end else begin : g_noskid
            assign in_ready = ~reset & (~w_out_valid | out_ready);
        end
    endgenerate

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = w_out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            if (CLEAR_ON_BUBBLE != 0) begin
                w_main_nxt = '0;
                w_skid_nxt = '0;
            end
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ST_BUSY;
                        w_main_nxt  = in_data;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire && (SKID != 0)) begin
                        w_state_nxt = ST_FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt = ST_BUSY;
                        w_main_nxt  = r_skid;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    assign out_valid = w_out_valid;
    assign out_data  = ((CLEAR_ON_BUBBLE != 0) && !w_out_valid) ? '0 : r_main;
    assign occupancy = occ_of(r_state);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid/clearing instance driven from a
// vector table plus hand sequences, and a no-skid/holding instance.
module tb_pipe_stage_skid;

    logic        clock = 1'b0;
    logic        reset;

    logic        a_flush, a_iv, a_ir, a_ov, a_ordy;
    logic [31:0] a_d, a_od;
    logic [1:0]  a_occ;
    logic [3:0]  a_st;

    logic        b_flush, b_iv, b_ir, b_ov, b_ordy;
    logic [31:0] b_d, b_od;
    logic [1:0]  b_occ;
    logic [15:0] b_st;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pipe_stage_skid #(.W(32), .SKID(1), .CLEAR_ON_BUBBLE(1), .CNT_W(4)) u_a (
        .clock(clock), .reset(reset), .flush(a_flush),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
        .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od),
        .occupancy(a_occ), .stall_cnt(a_st)
    );

    pipe_stage_skid #(.W(32), .SKID(0), .CLEAR_ON_BUBBLE(0), .CNT_W(16)) u_b (
        .clock(clock), .reset(reset), .flush(b_flush),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
        .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od),
        .occupancy(b_occ), .stall_cnt(b_st)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
        logic [3:0]  e_st;
    } vec_t;

    vec_t tv[17];

    initial begin
        // inputs for one cycle -> outputs after that edge
        tv[0]  = '{1'b1, 32'h11,       1'b1, 1'b0, 1'b1, 1'b1, 32'h11,       2'd1, 4'd0};
        tv[1]  = '{1'b1, 32'h22,       1'b1, 1'b0, 1'b1, 1'b1, 32'h22,       2'd1, 4'd0};
        tv[2]  = '{1'b1, 32'h33,       1'b1, 1'b0, 1'b1, 1'b1, 32'h33,       2'd1, 4'd0};
        tv[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        2'd0, 4'd0};
        tv[4]  = '{1'b1, 32'hA0,       1'b0, 1'b0, 1'b1, 1'b1, 32'hA0,       2'd1, 4'd0};
        tv[5]  = '{1'b1, 32'hA1,       1'b0, 1'b0, 1'b0, 1'b1, 32'hA0,       2'd2, 4'd1};
        tv[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hA0,       2'd2, 4'd2};
        tv[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'hA1,       2'd1, 4'd2};
        tv[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        2'd0, 4'd2};
        tv[9]  = '{1'b1, 32'hB0,       1'b0, 1'b0, 1'b1, 1'b1, 32'hB0,       2'd1, 4'd2};
        tv[10] = '{1'b1, 32'hB1,       1'b0, 1'b0, 1'b0, 1'b1, 32'hB0,       2'd2, 4'd3};
        tv[11] = '{1'b1, 32'hFF,       1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        2'd0, 4'd4};
        tv[12] = '{1'b1, 32'hC0,       1'b1, 1'b0, 1'b1, 1'b1, 32'hC0,       2'd1, 4'd4};
        tv[13] = '{1'b1, 32'hFF,       1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        2'd0, 4'd5};
        tv[14] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        2'd0, 4'd5};
        tv[15] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 2'd1, 4'd5};
        tv[16] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        2'd0, 4'd5};

        reset = 1'b1;
        a_flush = 0; a_iv = 0; a_d = 0; a_ordy = 0;
        b_flush = 0; b_iv = 0; b_d = 0; b_ordy = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ir_a", {31'd0, a_ir}, 0);
        chk("rst_ir_b", {31'd0, b_ir}, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rel_ir_a", {31'd0, a_ir}, 1);
        chk("rel_ov_a", {31'd0, a_ov}, 0);
        chk("rel_od_a", a_od, 0);
        chk("rel_occ_a", {30'd0, a_occ}, 0);
        chk("rel_st_a", {28'd0, a_st}, 0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            a_iv = tv[i].iv; a_d = tv[i].d; a_ordy = tv[i].ordy; a_flush = tv[i].fl;
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_ir", i),  {31'd0, a_ir},  {31'd0, tv[i].e_ir});
            chk($sformatf("v%0d_ov", i),  {31'd0, a_ov},  {31'd0, tv[i].e_ov});
            chk($sformatf("v%0d_od", i),  a_od,           tv[i].e_od);
            chk($sformatf("v%0d_occ", i), {30'd0, a_occ}, {30'd0, tv[i].e_occ});
            chk($sformatf("v%0d_st", i),  {28'd0, a_st},  {28'd0, tv[i].e_st});
        end

        // stall counter saturation, unaffected by flush
        @(negedge clock);
        a_iv = 0; a_flush = 0; a_ordy = 0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        @(negedge clock);
        a_iv = 1; a_d = 32'h77; a_ordy = 0;
        @(posedge clock);
        #1;
        chk("sat_start", {28'd0, a_st}, 0);
        @(negedge clock);
        a_iv = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock);
            #1;
            chk($sformatf("sat_%0d", n), {28'd0, a_st}, (n > 15) ? 15 : n);
        end
        @(negedge clock);
        a_flush = 1;
        @(posedge clock);
        #1;
        a_flush = 0;
        chk("sat_flush_st", {28'd0, a_st}, 15);
        chk("sat_flush_ov", {31'd0, a_ov}, 0);
        @(posedge clock);
        #1;
        chk("sat_hold_st", {28'd0, a_st}, 15);

        // asynchronous reset while FULL drops everything at once
        @(negedge clock);
        a_iv = 1; a_d = 32'h99; a_ordy = 0;
        @(negedge clock);
        a_d = 32'h9A;
        @(negedge clock);
        a_iv = 0;
        chk("mid_occ_pre", {30'd0, a_occ}, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_ov", {31'd0, a_ov}, 0);
        chk("mid_occ", {30'd0, a_occ}, 0);
        chk("mid_od", a_od, 0);
        chk("mid_st", {28'd0, a_st}, 0);
        chk("mid_ir", {31'd0, a_ir}, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("mid_after_ov", {31'd0, a_ov}, 0);

        // SKID=0, CLEAR_ON_BUBBLE=0 instance
        @(negedge clock);
        b_iv = 1; b_d = 32'hDEADBEEF; b_ordy = 1;
        #1;
        chk("b_ir_empty", {31'd0, b_ir}, 1);
        @(posedge clock);
        #1;
        chk("b_ov1", {31'd0, b_ov}, 1);
        chk("b_od1", b_od, 32'hDEADBEEF);
        @(negedge clock);
        b_iv = 0;
        @(posedge clock);
        #1;
        chk("b_bub_ov", {31'd0, b_ov}, 0);
        chk("b_bub_od", b_od, 32'hDEADBEEF);
        chk("b_bub_occ", {30'd0, b_occ}, 0);
        @(negedge clock);
        b_iv = 1; b_d = 32'h55; b_ordy = 0;
        @(posedge clock);
        #1;
        chk("b_od55", b_od, 32'h55);
        chk("b_occ1", {30'd0, b_occ}, 1);
        @(negedge clock);
        b_d = 32'h66;
        #1;
        chk("b_ir_stall", {31'd0, b_ir}, 0);
        @(posedge clock);
        #1;
        chk("b_od_held", b_od, 32'h55);
        @(negedge clock);
        b_ordy = 1;
        #1;
        chk("b_ir_comb", {31'd0, b_ir}, 1);
        @(posedge clock);
        #1;
        chk("b_ov66", {31'd0, b_ov}, 1);
        chk("b_od66", b_od, 32'h66);
        chk("b_occ66", {30'd0, b_occ}, 1);
        @(negedge clock);
        b_iv = 0;
        @(posedge clock);
        #1;
        chk("b_drain_ov", {31'd0, b_ov}, 0);
        chk("b_drain_od", b_od, 32'h66);
        chk("b_st", {16'd0, b_st}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
